// File: rtl/sync_counter_pkg.sv
// sync_counter_pkg: shared constants and Gray-code helpers for fifo_sync_counter
// Contents:
//   DEFAULT_DATA_WIDTH - default counter width (4)
//   bin2gray/gray2bin  - 32-bit conversions; callers truncate to their own width
//   all_ones           - terminal (all-ones) value for a given width, 32-bit
package sync_counter_pkg;
    localparam int DEFAULT_DATA_WIDTH = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [31:0] all_ones(input int w);
        return (w >= 32) ? '1 : ((32'(1) << w) - 32'(1));
    endfunction
endpackage

// File: rtl/gray_encode_reg.sv
// gray_encode_reg: registered binary-to-Gray conversion of a counter's next value
// Ports:
//   i_clk      - rising-edge clock
//   i_rst      - asynchronous active-low reset, clears o_gray
//   i_bin_next - binary value the counter will hold after this edge
//   o_gray     - registered Gray code, aligned with the counter's binary register
module gray_encode_reg
    import sync_counter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_bin_next,
    output logic [DATA_WIDTH-1:0] o_gray
);
    logic [31:0] w_gray_full;

    assign w_gray_full = bin2gray(32'(i_bin_next));

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) o_gray <= '0;
        else        o_gray <= w_gray_full[DATA_WIDTH-1:0];
endmodule

// File: rtl/fifo_sync_counter.sv
// fifo_sync_counter: enable-gated wrap-around up-counter for FIFO pointers
// Ports:
//   i_clk      - rising-edge clock
//   i_rst      - asynchronous active-low reset (0 = reset)
//   i_enable   - count enable, sampled on the rising edge
//   o_data_out - registered binary count
//   o_wrap     - registered one-cycle pulse after an all-ones -> 0 wrap
//   o_gray_out - registered Gray copy of the count, only with SYNC_COUNTER_GRAY_OUT_EN
module fifo_sync_counter
    import sync_counter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    output logic [DATA_WIDTH-1:0] o_data_out,
`ifdef SYNC_COUNTER_GRAY_OUT_EN
    output logic [DATA_WIDTH-1:0] o_gray_out,
`endif
    output logic                  o_wrap
);
    logic [DATA_WIDTH-1:0] r_count;
    logic                  r_wrap;
    logic [DATA_WIDTH-1:0] w_next;
    logic                  w_wrap;

    // wrap is the discarded carry out of the MSB when incrementing from all-ones
    assign w_wrap = i_enable && (r_count == DATA_WIDTH'(all_ones(DATA_WIDTH)));
    assign w_next = i_enable ? r_count + DATA_WIDTH'(1) : r_count;

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_wrap;
        end

    assign o_data_out = r_count;
    assign o_wrap     = r_wrap;

`ifdef SYNC_COUNTER_GRAY_OUT_EN
    // encoding the next value keeps the Gray register on the same edge as r_count
    gray_encode_reg #(.DATA_WIDTH(DATA_WIDTH)) u_gray (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_bin_next (w_next),
        .o_gray     (o_gray_out)
    );
`endif

    a_enable_known: assert property (@(posedge i_clk) disable iff (!i_rst) !$isunknown(i_enable))
        else $error("i_enable is X/Z outside reset");
endmodule

// File: tb/tb_fifo_sync_counter.sv
// tb_fifo_sync_counter: table-driven, hand-sequenced and randomized checks of fifo_sync_counter
module tb_fifo_sync_counter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         i_enable = 1'b0;
    logic [W-1:0] o_data_out;
    logic         o_wrap;
`ifdef SYNC_COUNTER_GRAY_OUT_EN
    logic [W-1:0] o_gray_out;
    logic [W-1:0] prev_gray;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic         rst;
        logic         en;
        logic [W-1:0] d;
        logic         w;
    } vec_t;
    vec_t vecs[$];

    int m_cnt;
    bit m_wrap;

    always #5 clk = ~clk;

    fifo_sync_counter #(.DATA_WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .o_data_out (o_data_out),
`ifdef SYNC_COUNTER_GRAY_OUT_EN
        .o_gray_out (o_gray_out),
`endif
        .o_wrap     (o_wrap)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step(input logic rst, input logic en);
        @(negedge clk);
        i_rst = rst;
        i_enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input int d, input bit w);
        chk({nm, " data"}, 32'(o_data_out), 32'(d));
        chk({nm, " wrap"}, 32'(o_wrap), 32'(w));
`ifdef SYNC_COUNTER_GRAY_OUT_EN
        chk({nm, " gray"}, 32'(o_gray_out), 32'(d ^ (d >> 1)));
`endif
    endtask

    initial begin
        // reset hold, gated counting, climb to terminal, hold at terminal, wrap
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b0});
        for (int i = 1; i <= 5; i++) vecs.push_back('{1'b1, 1'b1, W'(i), 1'b0});
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 1'b0, 4'd5, 1'b0});
        for (int i = 6; i <= 15; i++) vecs.push_back('{1'b1, 1'b1, W'(i), 1'b0});
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 1'b0, 4'd15, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'd0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 4'd1, 1'b0});

        #1;
        chk_out("reset_initial", 0, 0);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en);
            chk_out($sformatf("vec%0d", i), int'(vecs[i].d), vecs[i].w);
        end

        // async reset mid-count at 9, observed before the next edge
        step(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1);
        chk_out("pre_async", 9, 0);
        @(negedge clk);
        i_enable = 1'b0;
        #2 i_rst = 1'b0;
        #1 chk_out("async_mid", 0, 0);
        @(negedge clk);
        i_rst = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk_out("after_async", 2, 0);

        // async reset clears a pending wrap pulse
        for (int i = 2; i < 15; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk_out("wrap_pending", 0, 1);
        @(negedge clk);
        i_enable = 1'b0;
        #2 i_rst = 1'b0;
        #1 chk_out("wrap_cleared", 0, 0);
        @(negedge clk);
        i_rst = 1'b1;

`ifdef SYNC_COUNTER_GRAY_OUT_EN
        // 16 consecutive enabled edges: single-bit Gray steps, including across wrap
        prev_gray = o_gray_out;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("gray_onebit%0d", i), 32'($countones(prev_gray ^ o_gray_out)), 32'd1);
            chk($sformatf("gray_seq%0d", i), 32'(o_gray_out), 32'((i % 16) ^ ((i % 16) >> 1)));
            prev_gray = o_gray_out;
        end
        step(1'b0, 1'b0);
        @(negedge clk);
        i_rst = 1'b1;
`endif

        // randomized run against an arithmetic model, with occasional resets
        m_cnt = int'(o_data_out);
        m_wrap = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic r, e;
            r = ($urandom_range(0, 39) != 0);
            e = 1'($urandom_range(0, 3) != 0);
            step(r, e);
            if (!r) begin
                m_cnt = 0;
                m_wrap = 1'b0;
            end else begin
                m_wrap = e && (m_cnt == (1 << W) - 1);
                if (e) m_cnt = (m_cnt + 1) % (1 << W);
            end
            chk_out($sformatf("rand%0d", i), m_cnt, m_wrap);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
